glip_loopback_tester: RTL and testbench

Parametrised successor to the fixed 16-bit GLIP loopback. It terminates one GLIP FIFO channel pair: in_* receives words from the host, out_* sends words to it. It runs in one of four run-time modes: buffered loopback, pattern generation, pattern checking, or generation plus checking. It sits between the GLIP backend toplevel and user logic for link bring-up and throughput/error testing.

---
 rtl/glip_loopback_pkg.sv | 22 ++
 rtl/glip_loopback_fifo.sv | 53 +++++
 rtl/glip_loopback_tester.sv | 111 +++++++++++
 tb/tb_glip_loopback_tester.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glip_loopback_pkg.sv
// Shared types for the GLIP loopback tester: run-time mode encoding and
// checker counter width.
package glip_loopback_pkg;

  typedef enum logic [1:0] {
    MODE_LOOPBACK  = 2'd0,
    MODE_GEN       = 2'd1,
    MODE_CHECK     = 2'd2,
    MODE_GEN_CHECK = 2'd3
  } mode_e;

  localparam int ERR_WIDTH = 16;

  function automatic logic is_gen(input mode_e m);
    return (m == MODE_GEN) || (m == MODE_GEN_CHECK);
  endfunction

  function automatic logic is_check(input mode_e m);
    return (m == MODE_CHECK) || (m == MODE_GEN_CHECK);
  endfunction

endpackage

// File: rtl/glip_loopback_fifo.sv
// Synchronous FIFO for the loopback path: registered storage, head word on
// dout, occupancy from wide pointers so full and empty stay distinct.
module glip_loopback_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: state updates in clocked blocks use <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/glip_loopback_tester.sv
// GLIP channel-pair terminator for link bring-up: buffered loopback, counter
// pattern generator, pattern checker, or generator plus checker.
module glip_loopback_tester
  import glip_loopback_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]     rx_count,
  output logic [ERR_WIDTH-1:0]     err_count,
  output logic                     err_seen
);

  mode_e            mode_in;
  mode_e            mode_q;
  logic             clr;
  logic             lb;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] gen_cnt_q;
  logic [WIDTH-1:0] exp_cnt_q;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  // A mode change behaves exactly like an explicit clear for one edge.
  assign mode_in  = mode_e'(mode);
  assign clr      = clear || (mode_in != mode_q);
  assign lb       = (mode_q == MODE_LOOPBACK);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    if (!rst && !clr) begin
      if (lb) begin
        in_ready  = !fifo_full;
        out_valid = !fifo_empty;
      end else begin
        in_ready  = 1'b1;
        out_valid = is_gen(mode_q);
      end
    end
    if (out_valid) out_data = lb ? fifo_dout : gen_cnt_q;
  end

  glip_loopback_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clr),
    .push  (in_fire && lb),
    .din   (in_data),
    .pop   (out_fire && lb),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_LOOPBACK;
      gen_cnt_q <= '0;
      exp_cnt_q <= '0;
      rx_count  <= '0;
      err_count <= '0;
      err_seen  <= 1'b0;
    end else begin
      mode_q <= mode_in;
      if (clr) begin
        gen_cnt_q <= '0;
        exp_cnt_q <= '0;
        rx_count  <= '0;
        err_count <= '0;
        err_seen  <= 1'b0;
      end else begin
        if (in_fire) rx_count <= rx_count + 1'b1;
        if (out_fire && is_gen(mode_q)) gen_cnt_q <= gen_cnt_q + 1'b1;
        if (in_fire && is_check(mode_q)) begin
          if (in_data == exp_cnt_q) begin
            exp_cnt_q <= exp_cnt_q + 1'b1;
          end else begin
            // Resync to the received word so one glitch costs one error.
            exp_cnt_q <= in_data + 1'b1;
            err_seen  <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_glip_loopback_tester.sv
// Scoreboard bench for glip_loopback_tester: a 16-bit instance for loopback,
// checker and reset/mode tests, and an 8-bit instance for generator wrap.
module tb_glip_loopback_tester;
  import glip_loopback_pkg::*;

  localparam int W = 16, D = 16, CW = 32, W8 = 8, D8 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]            mode;
  logic                  clear;
  logic [W-1:0]          in_data;
  logic                  in_valid, in_ready;
  logic [W-1:0]          out_data;
  logic                  out_valid, out_ready;
  logic [$clog2(D):0]    fifo_level;
  logic [CW-1:0]         rx_count;
  logic [ERR_WIDTH-1:0]  err_count;
  logic                  err_seen;

  logic [1:0]            mode8;
  logic                  clear8;
  logic [W8-1:0]         in_data8;
  logic                  in_valid8, in_ready8;
  logic [W8-1:0]         out_data8;
  logic                  out_valid8, out_ready8;
  logic [$clog2(D8):0]   fifo_level8;
  logic [CW-1:0]         rx_count8;
  logic [ERR_WIDTH-1:0]  err_count8;
  logic                  err_seen8;

  glip_loopback_tester #(.WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .rx_count(rx_count),
    .err_count(err_count), .err_seen(err_seen)
  );

  glip_loopback_tester #(.WIDTH(W8), .DEPTH(D8), .CNT_WIDTH(CW)) dut8 (
    .clk(clk), .rst(rst), .mode(mode8), .clear(clear8),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .fifo_level(fifo_level8), .rx_count(rx_count8),
    .err_count(err_count8), .err_seen(err_seen8)
  );

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [W8-1:0] exp8_q[$];
  exp_t          e_mon;
  logic [W8-1:0] e8_mon;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            pops8    = 0;
  bit            lb_track = 1'b0;
  bit            chk_lat  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Loopback words are expected back in acceptance order; GEN words are queued by the stimulus.
  always @(negedge clk) begin
    if (lb_track && in_valid && in_ready) exp_q.push_back('{data: in_data, cyc: cyc});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got 0x%0h, expected no transfer", out_data);
      end else begin
        e_mon = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e_mon.data));
        if (chk_lat) check("latency", 64'(cyc - e_mon.cyc), 64'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid8 && out_ready8) begin
      pops8++;
      if (exp8_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL gen8_unexpected: got 0x%0h, expected no transfer", out_data8);
      end else begin
        e8_mon = exp8_q.pop_front();
        check("gen8_data", 64'(out_data8), 64'(e8_mon));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted d.
  task automatic send_word(input logic [W-1:0] d);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word 0x%0h not accepted within 50 cycles", d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] chk_seq [6];
    int           k;
    chk_seq = '{16'd0, 16'd1, 16'd2, 16'd7, 16'd8, 16'd9};

    rst = 1'b1; mode = 2'd0; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    mode8 = 2'd1; clear8 = 1'b0; in_data8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b0;

    #12;
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_in_ready",   64'(in_ready),   64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_rx_count",   64'(rx_count),   64'd0);
    check("rst_err_count",  64'(err_count),  64'd0);
    check("rst_err_seen",   64'(err_seen),   64'd0);
    check("rst_out_data",   64'(out_data),   64'd0);
    check("rst_out_valid8", 64'(out_valid8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);

    // Loopback, back-to-back, one-cycle latency.
    lb_track = 1'b1; chk_lat = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send_word(W'(i));
    in_valid = 1'b0;
    wait_cycles(3);
    chk_lat = 1'b0;
    check("lb_rx_count", 64'(rx_count), 64'd5);
    check("lb_drained",  64'(exp_q.size()), 64'd0);
    check("lb_level0",   64'(fifo_level), 64'd0);

    // Loopback fill to full, then drain.
    clear = 1'b1; wait_cycles(1); clear = 1'b0;
    check("clear_rx_count", 64'(rx_count), 64'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_word(W'(16'h0100 + i));
    in_data = 16'h0110;
    @(negedge clk);
    check("full_in_ready",  64'(in_ready),   64'd0);
    check("full_level",     64'(fifo_level), 64'd16);
    check("full_out_valid", 64'(out_valid),  64'd1);
    wait_cycles(3);
    check("full_hold_level", 64'(fifo_level), 64'd16);
    check("full_hold_rx",    64'(rx_count),   64'd16);
    out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_no_push", 64'(in_ready), 64'd0);
    #1 in_valid = 1'b0;
    k = 0;
    while (fifo_level != 0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_level", 64'(fifo_level), 64'd0);
    check("drain_sb",    64'(exp_q.size()), 64'd0);
    check("drain_rx",    64'(rx_count), 64'd16);
    lb_track = 1'b0;

    // GEN on the 8-bit instance: 260 transfers with stalls, wrapping 255 -> 0.
    for (int i = 0; i < 260; i++) exp8_q.push_back(W8'(i % 256));
    for (int j = 0; j < 3000 && pops8 < 260; j++) begin
      out_ready8 = ((j % 3) != 1);
      @(posedge clk);
      #1;
    end
    out_ready8 = 1'b0;
    @(negedge clk);
    check("gen8_count",     64'(pops8), 64'd260);
    check("gen8_sb_empty",  64'(exp8_q.size()), 64'd0);
    check("gen8_next_data", 64'(out_data8), 64'd4);
    check("gen8_valid",     64'(out_valid8), 64'd1);

    // CHECK: one error, resync, then clear.
    @(posedge clk); #1;
    mode = 2'd2;
    wait_cycles(2);
    for (int i = 0; i < 6; i++) send_word(chk_seq[i]);
    in_valid = 1'b0;
    wait_cycles(1);
    check("chk_err_count", 64'(err_count), 64'd1);
    check("chk_err_seen",  64'(err_seen),  64'd1);
    check("chk_rx_count",  64'(rx_count),  64'd6);
    check("chk_out_valid", 64'(out_valid), 64'd0);
    clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_err_count", 64'(err_count), 64'd0);
    check("clr_err_seen",  64'(err_seen),  64'd0);
    check("clr_rx_count",  64'(rx_count),  64'd0);
    for (int i = 0; i < 3; i++) send_word(W'(i));
    in_valid = 1'b0;
    wait_cycles(1);
    check("restart_err", 64'(err_count), 64'd0);
    check("restart_rx",  64'(rx_count),  64'd3);

    // CHECK saturation: 70000 identical words, each a mismatch.
    clear = 1'b1; wait_cycles(1); clear = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234;
    wait_cycles(65534);
    check("sat_fffe", 64'(err_count), 64'hFFFE);
    wait_cycles(1);
    check("sat_ffff", 64'(err_count), 64'hFFFF);
    wait_cycles(4465);
    check("sat_hold",  64'(err_count), 64'hFFFF);
    check("sat_rx",    64'(rx_count),  64'd70000);
    check("sat_seen",  64'(err_seen),  64'd1);
    in_valid = 1'b0;

    // Asynchronous reset with five words queued.
    mode = 2'd0;
    wait_cycles(2);
    lb_track = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(W'(16'h00A0 + i));
    in_valid = 1'b0;
    check("pre_rst_level", 64'(fifo_level), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid),  64'd0);
    check("arst_in_ready",  64'(in_ready),   64'd0);
    check("arst_level",     64'(fifo_level), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);

    // LOOPBACK -> GEN with data queued: flushed, generator starts at 0.
    for (int i = 0; i < 3; i++) send_word(W'(16'h00B0 + i));
    in_valid = 1'b0;
    check("pre_switch_level", 64'(fifo_level), 64'd3);
    lb_track = 1'b0;
    mode = 2'd1;
    @(negedge clk);
    check("switch_in_ready",  64'(in_ready),  64'd0);
    check("switch_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('{data: W'(i), cyc: 0});
    @(posedge clk); #1;
    check("switch_level", 64'(fifo_level), 64'd0);
    out_ready = 1'b1;
    wait_cycles(3);
    out_ready = 1'b0;
    @(negedge clk);
    check("switch_sb_empty", 64'(exp_q.size()), 64'd0);
    check("switch_next",     64'(out_data), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
